// File: rtl/hwpe_kernel_adapter_gen_pkg.sv
// hwpe_kernel_adapter_gen_pkg: FSM state encoding and default counter width shared by the adapter
package hwpe_kernel_adapter_gen_pkg;
  localparam int unsigned CNT_W_DEF = 16;
  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_RUN  = 1'b1;
  typedef enum logic [0:0] {IDLE = ST_IDLE, RUN = ST_RUN} state_e;
endpackage

// File: rtl/hwpe_kernel_adapter_gen_if.sv
// hwpe_kernel_adapter_gen_if: valid/ready taps of the monitored input and output streams
interface hwpe_kernel_adapter_gen_if #(
  parameter int unsigned N_IN  = 3,
  parameter int unsigned N_OUT = 1
) ();
  logic [N_IN-1:0]  in_valid;
  logic [N_IN-1:0]  in_ready;
  logic [N_OUT-1:0] out_valid;
  logic [N_OUT-1:0] out_ready;
  modport master (output in_valid, in_ready, out_valid, out_ready);
  modport slave  (input  in_valid, in_ready, out_valid, out_ready);
endinterface

// File: rtl/hwpe_kernel_adapter_hs_cnt.sv
// hwpe_kernel_adapter_hs_cnt: saturating handshake counter; a handshake during clear starts the next group at 1
module hwpe_kernel_adapter_hs_cnt #(
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             clr,
  input  logic             en,
  input  logic [CNT_W-1:0] max,
  output logic             done
);
  logic [CNT_W-1:0] cnt;
  assign done = cnt == max;
  always_ff @(posedge clk_i or negedge rst_ni)
    if (!rst_ni) cnt <= '0;
    else if (clr) cnt <= CNT_W'(en);
    else if (en && !done) cnt <= cnt + 1'b1;
endmodule

// File: rtl/hwpe_kernel_adapter_gen.sv
// hwpe_kernel_adapter_gen: groups stream handshakes into ready/done pulses per job; HWPE_KERNEL_ADAPTER_GEN_ERR_CHECK_EN enables err_o
module hwpe_kernel_adapter_gen
  import hwpe_kernel_adapter_gen_pkg::*;
#(
  parameter int unsigned N_IN  = 3,
  parameter int unsigned N_OUT = 1,
  parameter int unsigned CNT_W = CNT_W_DEF
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic                   start_i,
  input  logic [N_IN*CNT_W-1:0]  max_in_i,
  input  logic [N_OUT*CNT_W-1:0] max_out_i,
  input  logic [CNT_W-1:0]       n_groups_i,
  hwpe_kernel_adapter_gen_if.slave hs,
  output logic                   ready_o,
  output logic                   done_o,
  output logic                   idle_o,
  output logic [CNT_W-1:0]       grp_cnt_o,
  output logic                   err_o
);
  state_e                 state_q;
  logic [N_IN*CNT_W-1:0]  max_in_nz, max_in_q;
  logic [N_OUT*CNT_W-1:0] max_out_nz, max_out_q;
  logic [CNT_W-1:0]       ng_q;
  logic [N_IN-1:0]        in_hs, in_done;
  logic [N_OUT-1:0]       out_hs, out_done;
  logic                   run, fin, fire_in, fire_out;
  assign run      = state_q == RUN;
  assign fin      = grp_cnt_o == ng_q;
  assign in_hs    = hs.in_valid & hs.in_ready;
  assign out_hs   = hs.out_valid & hs.out_ready;
  // group pulses stop once the job has reached its group count
  assign fire_in  = run & ~fin & ~start_i & (&in_done);
  assign fire_out = run & ~fin & ~start_i & (&out_done);
  for (genvar i = 0; i < N_IN; i++) begin : g_in
    assign max_in_nz[i*CNT_W +: CNT_W] = (max_in_i[i*CNT_W +: CNT_W] == '0) ? CNT_W'(1) : max_in_i[i*CNT_W +: CNT_W];
    hwpe_kernel_adapter_hs_cnt #(.CNT_W(CNT_W)) u_cnt (
      .clk_i,
      .rst_ni,
      .clr  (start_i | fire_in),
      .en   (run & ~start_i & in_hs[i]),
      .max  (max_in_q[i*CNT_W +: CNT_W]),
      .done (in_done[i])
    );
  end
  for (genvar i = 0; i < N_OUT; i++) begin : g_out
    assign max_out_nz[i*CNT_W +: CNT_W] = (max_out_i[i*CNT_W +: CNT_W] == '0) ? CNT_W'(1) : max_out_i[i*CNT_W +: CNT_W];
    hwpe_kernel_adapter_hs_cnt #(.CNT_W(CNT_W)) u_cnt (
      .clk_i,
      .rst_ni,
      .clr  (start_i | fire_out),
      .en   (run & ~start_i & out_hs[i]),
      .max  (max_out_q[i*CNT_W +: CNT_W]),
      .done (out_done[i])
    );
  end
  always_ff @(posedge clk_i or negedge rst_ni)
    if (!rst_ni) begin
      state_q   <= IDLE;
      idle_o    <= 1'b1;
      ready_o   <= 1'b0;
      done_o    <= 1'b0;
      grp_cnt_o <= '0;
      max_in_q  <= '0;
      max_out_q <= '0;
      ng_q      <= '0;
    end else begin
      ready_o <= fire_in;
      done_o  <= fire_out;
      if (start_i) begin
        state_q   <= RUN;
        idle_o    <= 1'b0;
        grp_cnt_o <= '0;
        max_in_q  <= max_in_nz;
        max_out_q <= max_out_nz;
        ng_q      <= (n_groups_i == '0) ? CNT_W'(1) : n_groups_i;
      end else begin
        if (fire_out) grp_cnt_o <= grp_cnt_o + 1'b1;
        if (run && fin) begin
          state_q <= IDLE;
          idle_o  <= 1'b1;
        end
      end
    end
`ifdef HWPE_KERNEL_ADAPTER_GEN_ERR_CHECK_EN
  logic [N_IN-1:0]  in_bad;
  logic [N_OUT-1:0] out_bad;
  // a handshake is bad when idle, or when its channel is saturated and not being cleared
  assign in_bad  = in_hs & (run ? (in_done & ~{N_IN{fire_in}}) : {N_IN{1'b1}});
  assign out_bad = out_hs & (run ? (out_done & ~{N_OUT{fire_out}}) : {N_OUT{1'b1}});
  always_ff @(posedge clk_i or negedge rst_ni)
    if (!rst_ni) err_o <= 1'b0;
    else if (start_i) err_o <= 1'b0;
    else if (|in_bad || |out_bad) err_o <= 1'b1;
`else
  assign err_o = 1'b0;
`endif
endmodule
